// File: rtl/pwm_hbridge_driver.sv
// Complementary-direction PWM for one H-bridge, driven by a signed duty command.
// Duty is shadowed at period boundaries; direction reversals insert a dead time.
module pwm_hbridge_driver #(
    parameter int PWM_PERIOD      = 1600,
    parameter int DEADTIME_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [23:0] duty,
    input  logic        enable,
    output logic        pwm_a,
    output logic        pwm_b,
    output logic        dir,
    output logic        period_start,
    output logic        clamped
);

    typedef enum logic [1:0] {IDLE, FWD, REV, DEAD} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(PWM_PERIOD - 1);
    localparam logic [CNT_W-1:0] FULL_MAG  = CNT_W'(PWM_PERIOD);
    localparam logic [CNT_W-1:0] DEAD_LEN  = CNT_W'(DEADTIME_CYCLES);
    localparam logic [24:0]      PERIOD_25 = 25'(PWM_PERIOD);

    logic [CNT_W-1:0] cnt, cnt_next, dead_cnt, dead_cnt_next, mag;
    logic [23:0]      shadow_duty, eff_duty;
    logic [24:0]      duty_ext, abs_duty;
    logic             load, over, target_rev, target_rev_next;
    logic             pwm_a_next, pwm_b_next, dir_next;
    state_t           state, state_next;

    // On the boundary edge the incoming duty is what the shadow captures, so the
    // period about to start is evaluated from it directly.
    always_comb begin : period_logic
        load     = (cnt == LAST_CNT);
        cnt_next = load ? '0 : cnt + CNT_W'(1);
        eff_duty = load ? duty : shadow_duty;
        duty_ext = {eff_duty[23], eff_duty};
        abs_duty = eff_duty[23] ? -duty_ext : duty_ext;
        over     = (abs_duty > PERIOD_25);
        mag      = over ? FULL_MAG : abs_duty[CNT_W-1:0];
    end

    always_comb begin : fsm_logic
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_next      = state;
        target_rev_next = target_rev;
        dead_cnt_next   = dead_cnt;
        if (!enable) begin
            state_next = IDLE;
        end else if (load) begin
            if (eff_duty == '0) begin
                state_next = IDLE;
            end else if (!eff_duty[23]) begin
                if (state == REV || state == DEAD) begin
                    state_next      = DEAD;
                    target_rev_next = 1'b0;
                    dead_cnt_next   = CNT_W'(1);
                end else begin
                    state_next = FWD;
                end
            end else begin
                if (state == FWD || state == DEAD) begin
                    state_next      = DEAD;
                    target_rev_next = 1'b1;
                    dead_cnt_next   = CNT_W'(1);
                end else begin
                    state_next = REV;
                end
            end
        end else if (state == DEAD) begin
            // dead_cnt numbers the dead cycle currently on the outputs.
            if (dead_cnt >= DEAD_LEN) begin
                state_next = target_rev ? REV : FWD;
            end else begin
                dead_cnt_next = dead_cnt + CNT_W'(1);
            end
        end

        pwm_a_next = (state_next == FWD) && (cnt_next < mag);
        pwm_b_next = (state_next == REV) && (cnt_next < mag);
        dir_next   = (state_next == REV) || ((state_next == DEAD) && target_rev_next);
    end

    // Outputs are computed from the next counter value so they line up with it.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            shadow_duty  <= '0;
            state        <= IDLE;
            target_rev   <= 1'b0;
            dead_cnt     <= '0;
            pwm_a        <= 1'b0;
            pwm_b        <= 1'b0;
            dir          <= 1'b0;
            period_start <= 1'b0;
            clamped      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt          <= cnt_next;
            shadow_duty  <= eff_duty;
            state        <= state_next;
            target_rev   <= target_rev_next;
            dead_cnt     <= dead_cnt_next;
            pwm_a        <= pwm_a_next;
            pwm_b        <= pwm_b_next;
            dir          <= dir_next;
            period_start <= load;
            if (load) begin
                clamped <= over;
            end
        end
    end

endmodule

// File: tb/tb_pwm_hbridge_driver.sv
// Self-checking bench for pwm_hbridge_driver: per-period on-time, direction,
// clamp and dead-time vectors, plus shadow, live-enable and async-reset sequences.
module tb_pwm_hbridge_driver;

    localparam int P = 1600;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] duty = '0;
    logic        enable = 1'b0;
    logic        pwm_a, pwm_b, dir, period_start, clamped;

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;

    int a_on, b_on, first_on, dir_on, clamp_on, ps_on;
    int waited, highs;

    typedef struct {
        logic [23:0] duty;
        int          a_on;
        int          b_on;
        int          first_on;
        logic        dir;
        logic        clamp;
    } vec_t;

    vec_t tbl[15];

    pwm_hbridge_driver dut (
        .CLK          (CLK),
        .reset        (reset),
        .duty         (duty),
        .enable       (enable),
        .pwm_a        (pwm_a),
        .pwm_b        (pwm_b),
        .dir          (dir),
        .period_start (period_start),
        .clamped      (clamped)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (pwm_a && pwm_b) overlap_cnt++;
    end

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance to the next negedge on which period_start is high.
    task automatic wait_ps(output int n, output int h);
        n = 0;
        h = 0;
        do begin
            @(negedge CLK);
            n++;
            if (!period_start && (pwm_a || pwm_b)) h++;
        end while (!period_start && n < 2 * P);
        if (!period_start) check("period_start_timeout", 0, 1);
    endtask

    // Samples one full period starting at the current (period_start) negedge.
    task automatic run_period(input int c1, input logic [23:0] d1, input logic e1,
                              input int c2, input logic [23:0] d2, input logic e2);
        a_on = 0; b_on = 0; first_on = -1; dir_on = 0; clamp_on = 0; ps_on = 0;
        for (int k = 0; k < P; k++) begin
            if (k > 0) @(negedge CLK);
            if (pwm_a) a_on++;
            if (pwm_b) b_on++;
            if ((pwm_a || pwm_b) && first_on < 0) first_on = k;
            if (dir) dir_on++;
            if (clamped) clamp_on++;
            if (period_start) ps_on++;
            if (k == c1) begin duty = d1; enable = e1; end
            if (k == c2) begin duty = d2; enable = e2; end
        end
    endtask

    task automatic check_period(input string tag, input int ea, input int eb, input int ef,
                                input logic ed, input logic ec);
        check({tag, " a_on"}, a_on, ea);
        check({tag, " b_on"}, b_on, eb);
        check({tag, " first_on"}, first_on, ef);
        check({tag, " dir_cycles"}, dir_on, ed ? P : 0);
        check({tag, " clamp_cycles"}, clamp_on, ec ? P : 0);
        check({tag, " period_starts"}, ps_on, 1);
    endtask

    initial begin
        tbl[0]  = '{24'd400,       400,  0,    0,  1'b0, 1'b0};
        tbl[1]  = '{24'd400,       400,  0,    0,  1'b0, 1'b0};
        tbl[2]  = '{24'(-800),     0,    784,  16, 1'b1, 1'b0};
        tbl[3]  = '{24'(-800),     0,    800,  0,  1'b1, 1'b0};
        tbl[4]  = '{24'd400,       384,  0,    16, 1'b0, 1'b0};
        tbl[5]  = '{24'd5000,      1600, 0,    0,  1'b0, 1'b1};
        tbl[6]  = '{24'h800000,    0,    1584, 16, 1'b1, 1'b1};
        tbl[7]  = '{24'h800000,    0,    1600, 0,  1'b1, 1'b1};
        tbl[8]  = '{24'(-10),      0,    10,   0,  1'b1, 1'b0};
        tbl[9]  = '{24'd0,         0,    0,    -1, 1'b0, 1'b0};
        tbl[10] = '{24'(-16),      0,    16,   0,  1'b1, 1'b0};
        tbl[11] = '{24'd16,        0,    0,    -1, 1'b0, 1'b0};
        tbl[12] = '{24'd1600,      1600, 0,    0,  1'b0, 1'b0};
        tbl[13] = '{24'd1601,      1600, 0,    0,  1'b0, 1'b1};
        tbl[14] = '{24'(-1600),    0,    1584, 16, 1'b1, 1'b0};

        repeat (3) @(negedge CLK);
        check("reset_outputs", {pwm_a, pwm_b, dir, period_start, clamped}, 0);
        duty   = tbl[0].duty;
        enable = 1'b1;
        reset  = 1'b0;

        wait_ps(waited, highs);
        check("first_ps_latency", waited, P);
        check("first_period_idle", highs, 0);

        for (int i = 0; i < 15; i++) begin
            if (i < 14) run_period(0, tbl[i + 1].duty, 1'b1, -1, '0, 1'b1);
            else        run_period(-1, '0, 1'b1, -1, '0, 1'b1);
            check_period($sformatf("vec%0d", i), tbl[i].a_on, tbl[i].b_on, tbl[i].first_on,
                         tbl[i].dir, tbl[i].clamp);
            wait_ps(waited, highs);
        end

        // Shadowing: a mid-period duty change waits for the boundary.
        run_period(0, 24'd200, 1'b1, -1, '0, 1'b1);
        check("hold_-1600 b_on", b_on, 1600);
        wait_ps(waited, highs);
        run_period(-1, '0, 1'b1, -1, '0, 1'b1);
        check_period("rev_to_200", 184, 0, 16, 1'b0, 1'b0);
        wait_ps(waited, highs);
        run_period(700, 24'd1000, 1'b1, -1, '0, 1'b1);
        check_period("keep_200", 200, 0, 0, 1'b0, 1'b0);
        wait_ps(waited, highs);
        run_period(0, 24'd400, 1'b1, -1, '0, 1'b1);
        check_period("next_1000", 1000, 0, 0, 1'b0, 1'b0);

        // Live enable drop at counter 100, re-raise at 900.
        wait_ps(waited, highs);
        run_period(100, 24'd400, 1'b0, 900, 24'd400, 1'b1);
        check_period("enable_drop", 101, 0, 0, 1'b0, 1'b0);
        wait_ps(waited, highs);
        run_period(-1, '0, 1'b1, -1, '0, 1'b1);
        check_period("enable_resume", 400, 0, 0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a pulse.
        wait_ps(waited, highs);
        repeat (50) @(negedge CLK);
        check("pre_reset pwm_a", int'(pwm_a), 1);
        reset = 1'b1;
        duty  = 24'd300;
        #1;
        check("async_reset_outputs", {pwm_a, pwm_b, dir, period_start, clamped}, 0);
        @(negedge CLK);
        reset = 1'b0;
        wait_ps(waited, highs);
        check("post_reset_latency", waited, P);
        check("post_reset_idle", highs, 0);
        run_period(-1, '0, 1'b1, -1, '0, 1'b1);
        check_period("post_reset_300", 300, 0, 0, 1'b0, 1'b0);

        check("overlap_cycles", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_hbridge_driver.md
Name: pwm_hbridge_driver

Overview:
Downstream stage of the PID motor controller. Converts the signed 24-bit duty command into complementary-direction PWM for one H-bridge. Duty is double-buffered so it only changes at period boundaries. Direction reversals insert a dead time so both bridge legs are never driven in the same cycle.

Parameters:
PWM_PERIOD, 1600, clock cycles per PWM period (10 kHz at 16 MHz CLK); must be > DEADTIME_CYCLES and < 2^16
DEADTIME_CYCLES, 16, cycles both outputs are held low at the start of a period that reverses direction
CNT_W, 16, width of the period counter and dead-time counter

Ports:
CLK  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
duty  input  24  signed duty command (two's complement), sign = direction, magnitude = on-cycles
enable  input  1  1 = drive bridge; 0 = both outputs low
pwm_a  output  1  forward leg drive
pwm_b  output  1  reverse leg drive
dir  output  1  0 = forward or idle, 1 = reverse (active direction of the current period)
period_start  output  1  one-cycle pulse on the first cycle of every period
clamped  output  1  high for a whole period when |duty| > PWM_PERIOD

Behaviour:
- Interface: one clock, CLK; reset is asynchronous and active-high, named reset.
- Reset: counter=0, shadow duty=0, state=IDLE, dead counter=0; pwm_a, pwm_b, dir, period_start, clamped all 0, asynchronously.
- Period counter counts 0..PWM_PERIOD-1 and wraps to 0. It runs regardless of enable.
- Shadow load: on the edge where counter==PWM_PERIOD-1, the shadow captures duty and enable. The new value governs the period that begins next. Input changes mid-period have no effect until then. Latency is 1 to PWM_PERIOD cycles.
- Magnitude is |duty| computed at 25 bits, so -2^23 maps to 2^23. mag = min(|duty|, PWM_PERIOD). clamped = (|duty| > PWM_PERIOD), latched per period.
- FSM states: IDLE, FWD, REV, DEAD. Evaluation happens at each period boundary from the shadow values:
  - enable=0 or duty=0 -> IDLE.
  - duty>0: from FWD or IDLE -> FWD; from REV -> DEAD, target FWD.
  - duty<0: from REV or IDLE -> REV; from FWD -> DEAD, target REV.
  - DEAD -> target state once the dead counter reaches DEADTIME_CYCLES, within the same period.
  - A reversal seen while in DEAD re-targets. The dead counter restarts only at a period boundary.
- Outputs are registered, aligned so that period_start and the first on-cycle rise on the same edge.
  - FWD: pwm_a = (counter < mag), pwm_b = 0.
  - REV: pwm_b = (counter < mag), pwm_a = 0.
  - IDLE and DEAD: both 0.
  - After DEAD, the on-window is still counter < mag, so the reversal period's on-time is mag - DEADTIME_CYCLES (0 if mag <= DEADTIME_CYCLES).
- pwm_a and pwm_b are never both 1 in any cycle (invariant).
- dir: 1 in REV, and in DEAD targeting REV; else 0.
- Live enable: enable falling mid-period forces both outputs low on the next edge and sets state to IDLE. Drive resumes only at a later period boundary with the shadow enable = 1. The IDLE->REV/FWD entry needs no dead time because the outputs were low.
- mag = PWM_PERIOD gives an output that stays high continuously across the wrap.

Test Plan:
- Reset, enable=1, duty=+400 -> from the first period_start: pwm_a high exactly 400 of every 1600 cycles, pwm_b=0, dir=0, clamped=0.
- Steady +400, then duty=-800 -> reversal period: both low 16 cycles, then pwm_b high 784 cycles, dir=1. Following periods: pwm_b high 800, pwm_a never high.
- duty=+5000 -> pwm_a high continuously, clamped=1. Then duty=-8388608 -> one dead period (16 low, 1584 pwm_b), then pwm_b high continuously, clamped=1.
- duty=200, changed to 1000 at counter=700 -> the current period keeps 200 on-cycles; the next period has 1000.
- enable dropped at counter=100 with duty=+400 -> pwm_a low on the next edge. Re-raised at counter=900 -> outputs stay low until the boundary, then 400-cycle pulses resume with no dead time.
- reset asserted mid-pulse with pwm_a=1 -> all outputs 0 immediately without a clock. After release with duty=+300: the first period has no pulse (shadow=0), and pulses of 300 start from the following period.
